// File: rtl/md_sched.sv
// md_sched: sequences the multi-cycle multiply/divide unit and the HI/LO registers.
// An arithmetic op is accepted in E while the unit is idle. Its result is captured
// as "pending" on the start edge, and that pending value is committed to HI/LO after
// a fixed cycle count. A stall request holds any MDU op that is waiting in D.
// Optional feature macro: MD_MADD_EN enables ops 9 (MADD) and 10 (MSUB).
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDop,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_flush,
  input  logic        D_is_md,
  output logic        E_start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] E_MDout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [31:0]        ph;
  logic [31:0]        pl;
  logic               pok;

  logic               op_arith;
  logic               op_mul;
  logic               op_mthi;
  logic               op_mtlo;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvsr;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [63:0]        res;
  logic               res_ok;

  // Decode the E-stage op; a flushed op decodes as NONE.
  always_comb begin
    op_arith = 1'b0;
    op_mul   = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    if (!E_flush) begin
      case (E_MDop)
        OP_MULT, OP_MULTU: begin
          op_arith = 1'b1;
          op_mul   = 1'b1;
        end
        OP_DIV, OP_DIVU: op_arith = 1'b1;
`ifdef MD_MADD_EN
        OP_MADD, OP_MSUB: begin
          op_arith = 1'b1;
          op_mul   = 1'b1;
        end
`endif
        OP_MTHI: op_mthi = 1'b1;
        OP_MTLO: op_mtlo = 1'b1;
        default: op_arith = 1'b0;
      endcase
    end else begin
      op_arith = 1'b0;
    end
  end

  // Compute the full result from the E operands. A zero divisor is replaced by 1 so
  // that no X is produced, and res_ok marks the result as not to be committed.
  always_comb begin
    prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u = {32'd0, E_A} * {32'd0, E_B};
    dvsr   = (E_B == 32'd0) ? 32'd1 : E_B;
    q_s    = $signed(E_A) / $signed(dvsr);
    r_s    = $signed(E_A) % $signed(dvsr);
    res    = 64'd0;
    res_ok = 1'b1;
    case (E_MDop)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        res    = {r_s, q_s};
        res_ok = (E_B != 32'd0);
      end
      OP_DIVU: begin
        res    = {E_A % dvsr, E_A / dvsr};
        res_ok = (E_B != 32'd0);
      end
`ifdef MD_MADD_EN
      OP_MADD:  res = {HI, LO} + prod_s;
      OP_MSUB:  res = {HI, LO} - prod_s;
`endif
      default: begin
        res    = 64'd0;
        res_ok = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and start decision. Ops are accepted only while IDLE.
  always_comb begin
    state_nxt = state;
    E_start   = 1'b0;
    case (state)
      IDLE: begin
        E_start = op_arith;
        if (op_arith) state_nxt = RUN;
        else          state_nxt = IDLE;
      end
      RUN: begin
        if (cnt == CNT_ZERO) state_nxt = IDLE;
        else                 state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture the pending result on start, count down, commit HI/LO, and
  // perform MTHI/MTLO writes while idle. A flush never aborts a run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= CNT_ZERO;
      ph   <= 32'd0;
      pl   <= 32'd0;
      pok  <= 1'b0;
      HI   <= 32'd0;
      LO   <= 32'd0;
    end else if (E_start) begin
      ph   <= res[63:32];
      pl   <= res[31:0];
      pok  <= res_ok;
      cnt  <= op_mul ? MULT_LOAD : DIV_LOAD;
      busy <= 1'b1;
    end else if (state == RUN) begin
      if (cnt == CNT_ZERO) begin
        busy <= 1'b0;
        if (pok) begin
          HI <= ph;
          LO <= pl;
        end
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end else begin
      if (op_mthi) HI <= E_A;
      if (op_mtlo) LO <= E_A;
    end
  end

  // Move-from read port: drives the current HI or LO register.
  always_comb begin
    E_MDout = 32'd0;
    case (E_MDop)
      OP_MFHI: E_MDout = HI;
      OP_MFLO: E_MDout = LO;
      default: E_MDout = 32'd0;
    endcase
  end

  assign stall_md = D_is_md & (E_start | busy);

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequences the multi-cycle multiply/divide unit (MDU) and the HI/LO registers for the 5-stage pipeline.
- Accepts MDU ops from the E stage and runs each arithmetic op for a fixed cycle count.
- Commits HI/LO at completion and raises a stall request for the D stage while an MDU-dependent instruction must wait.
- Sits beside the E stage; its stall output is ORed into the hazard unit's freeze/bubble logic for regD/regE.

Parameters:
- MULT_CYCLES, 5, cycles busy after a mult/multu start (≥2).
- DIV_CYCLES, 10, cycles busy after a div/divu start (≥2).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- E_MDop  input  4  op in E: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MSUB; 11-15 = NONE
- E_A  input  32  rs operand (forwarded)
- E_B  input  32  rt operand (forwarded)
- E_flush  input  1  E-stage op is a bubble/killed; treat E_MDop as NONE
- D_is_md  input  1  instruction in D uses the MDU (any op 1-10)
- E_start  output  1  combinational: arithmetic op accepted this cycle
- busy  output  1  registered: MDU computing
- stall_md  output  1  combinational: D_is_md & (E_start | busy)
- E_MDout  output  32  combinational: HI for MFHI, LO for MFLO, else 0
- HI  output  32  current HI register
- LO  output  32  current LO register

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, busy=0, HI=0, LO=0, pending results 0. E_start=0 and stall_md=0 follow combinationally unless D_is_md is high.
- States:
  - IDLE: E_start = valid op in {1,2,3,4,(9,10)} & ~E_flush.
    - On the E_start edge: latch the result into pending {PH,PL}, load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES), go to RUN.
    - busy goes high on that same edge.
  - RUN: counter decrements each cycle.
    - On the edge where counter==0: HI<=PH, LO<=PL, busy<=0, go to IDLE.
    - busy is high for exactly N cycles after the start edge.
    - New HI/LO are visible the cycle busy falls.
- Results:
  - MULT: signed 64-bit product; MULTU: unsigned. {HI,LO} = product.
  - DIV/DIVU: LO = quotient, HI = remainder, signed truncating toward zero (remainder takes the dividend's sign) / unsigned.
  - Divisor 0: op still runs DIV_CYCLES, but HI/LO are left unchanged at completion.
- MTHI/MTLO: valid only in IDLE; write E_A to HI/LO at the clock edge, 1-cycle effect, busy stays 0.
- MFHI/MFLO: E_MDout reflects the current registers combinationally.
- Any op in E while busy or E_start: impossible by construction, because stall_md holds it in D.
  - The design ignores such ops; the bench asserts they never occur.
- E_flush=1: no start and no MTHI/MTLO write. A run already in progress is never aborted by a flush.
- stall_md is asserted combinationally in the cycle E_start fires, so a back-to-back MDU op in D is held.

Optional Feature:
- Macro MD_MADD_EN.
- Defined: ops 9 MADD / 10 MSUB compute {HI,LO} ± signed(E_A)*signed(E_B), mod 2^64.
  - They use the {HI,LO} current at the start edge and run MULT_CYCLES.
  - Otherwise they behave like MULT (start, busy, stall).
- Undefined: codes 9/10 decode as NONE: no start, no stall, HI/LO untouched.

Test Plan:
- Reset mid-RUN: start DIV, drop reset after 3 cycles -> busy=0, HI=LO=0 immediately; after release, a new op starts normally.
- MULT E_A=0xFFFFFFFD, E_B=5 (MULT_CYCLES=5) -> E_start=1 one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULTU on the same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV 7/0xFFFFFFFE -> after 10 cycles LO=0xFFFFFFFD, HI=0x00000001; DIVU 0xFFFFFFFF/2 -> LO=0x7FFFFFFF, HI=1; DIV by 0 after MTHI 0x1234 -> HI stays 0x1234.
- Back-to-back: MULT in E with MFLO in D (D_is_md=1) -> stall_md=1 in the start cycle and all 5 busy cycles, 0 in the cycle busy falls; MFLO then reads the new LO.
- MTLO E_A=0xABCD then MFLO next cycle -> E_MDout=0xABCD, busy never asserted; same MTLO with E_flush=1 -> LO unchanged.
- MD_MADD_EN: HI=0, LO=0xFFFFFFFF, MADD 1*1 -> HI=1, LO=0; then MSUB 2*1 -> HI=0, LO=0xFFFFFFFE. Without the macro, the same ops leave HI/LO untouched and busy=0.
